// File: rtl/ram_1k16_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_1k16_if
//  Description : Access bus for the ram_1k16 word store.
//                master : drives data_in, rd, wr, address; observes outputs.
//                slave  : observes requests; drives data_out, rd_valid, ready.
//  Signals     : data_in  [DATA_W] write data
//                rd                read enable
//                wr                write enable
//                address  [ADDR_W] word address
//                data_out [DATA_W] registered read data
//                rd_valid          data_out carries data from the previous edge
//                ready             clear engine done, accesses accepted
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_1k16_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              ready;

    modport master (
        output data_in, rd, wr, address,
        input  data_out, rd_valid, ready
    );

    modport slave (
        input  data_in, rd, wr, address,
        output data_out, rd_valid, ready
    );
endinterface
`default_nettype wire

// File: rtl/ram_1k16.sv
`default_nettype none
// ============================================================================
//  Module      : ram_1k16
//  Description : Single-port synchronous word RAM (2**ADDR_W x DATA_W) with
//                registered read data and a clear engine that zeroes every
//                word after each reset before accesses are accepted.
//  Ports       : clk    system clock, rising edge
//                rst_n  asynchronous active-low reset
//                bus    ram_1k16_if.slave (data_in, rd, wr, address,
//                       data_out, rd_valid, ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_1k16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    ram_1k16_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [ADDR_W-1:0] r_clr_ptr;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_accept;

    // ------------------------------------------------------------------
    // State register and clear pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: leave CLEAR on the edge that writes the last word
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_ptr == LAST_ADDR) w_state_next = ST_READY;
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: the single RAM port is owned by the clear engine while
    // clearing, and by the external bus once ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.address;
        w_mem_wdata = bus.data_in;
        w_rd_accept = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_ptr;
                w_mem_wdata = '0;
            end
            ST_READY: begin
                w_mem_we    = bus.wr;
                w_rd_accept = bus.rd;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Memory array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read port. On a simultaneous write the array read returns
    // the old word, so the incoming data is forwarded (write-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_data_out <= bus.wr ? bus.data_in : r_mem[w_mem_addr];
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
    assign bus.ready    = (r_state == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_ram_1k16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_1k16
//  Description : Self-checking bench for ram_1k16. Expected read data is
//                taken from a bench-side memory model and queued when a read
//                is driven; it is popped when rd_valid is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_1k16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BUDGET = DEPTH + 100;

    logic clk;
    logic rst_n;

    ram_1k16_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ram_1k16 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model [0:DEPTH-1];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_rd;
    bit                mdl_ready = 1'b0;

    // Drive one cycle of stimulus, record expectations, sample #1 after edge.
    task automatic drive(input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.rd      = r;
        bus.wr      = w;
        bus.address = a;
        bus.data_in = d;
        if (mdl_ready) begin
            if (r) exp_q.push_back(w ? d : model[a]);
            if (w) model[a] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q.delete();
        last_rd   = '0;
        mdl_ready = 1'b1;
    endtask

    // Reset, then clear with ignored accesses (wr addr 3 = 1234) during clear.
    task automatic test_reset();
        int n;
        logic [DATA_W-1:0] exp;
        rst_n = 1'b0;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.address = '0; bus.data_in = '0;
        mdl_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.data_out !== 16'h0 || bus.rd_valid !== 1'b0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: data_out=%h rd_valid=%b ready=%b, required 0/0/0",
                     bus.data_out, bus.rd_valid, bus.ready);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.wr      = 1'b1;
        bus.rd      = 1'b1;
        bus.address = 10'd3;
        bus.data_in = 16'h1234;
        n = 0;
        while (n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (n <= 5) begin
                checks++;
                if (bus.rd_valid !== 1'b0 || bus.data_out !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_ignore: cycle %0d rd_valid=%b data_out=%h, required 0/0000",
                             n, bus.rd_valid, bus.data_out);
                end
            end
            if (n == 5) begin
                bus.wr = 1'b0;
                bus.rd = 1'b0;
            end
            if (bus.ready === 1'b1) break;
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL clear_length: ready after %0d cycles, required %0d", n, DEPTH);
        end
        model_clear();
        drive(1'b1, 1'b0, 10'd5, '0);
        checks++;
        if (bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL read5_valid: rd_valid=%b, required 1", bus.rd_valid);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.data_out !== exp) begin
                errors++;
                $display("FAIL read5_data: data_out=%h, required %h", bus.data_out, exp);
            end
            last_rd = exp;
        end
        idle();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: rd_valid=%b, required 0", bus.rd_valid);
        end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] exp;
        drive(1'b0, 1'b1, 10'd1, 16'd1);
        drive(1'b0, 1'b1, 10'd2, 16'd2);
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(i), '0);
            checks++;
            if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_rd_valid: addr %0d rd_valid=%b, required 1", i, bus.rd_valid);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (bus.data_out !== exp) begin
                    errors++;
                    $display("FAIL wr_rd_data: addr %0d data_out=%h, required %h", i, bus.data_out, exp);
                end
                last_rd = exp;
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (bus.rd_valid !== 1'b0 || bus.data_out !== last_rd) begin
                errors++;
                $display("FAIL hold: cycle %0d rd_valid=%b data_out=%h, required 0/%h",
                         i, bus.rd_valid, bus.data_out, last_rd);
            end
        end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] exp;
        drive(1'b1, 1'b1, 10'd7, 16'hBEEF);
        exp = exp_q.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.data_out !== exp) begin
            errors++;
            $display("FAIL collision: rd_valid=%b data_out=%h, required 1/%h",
                     bus.rd_valid, bus.data_out, exp);
        end
        idle();
        drive(1'b1, 1'b0, 10'd7, '0);
        exp = exp_q.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.data_out !== exp) begin
            errors++;
            $display("FAIL collision_readback: rd_valid=%b data_out=%h, required 1/%h",
                     bus.rd_valid, bus.data_out, exp);
        end
        last_rd = exp;
    endtask

    // The write to addr 3 issued during clear must not have landed.
    task automatic test_clear_blocked();
        logic [DATA_W-1:0] exp;
        drive(1'b1, 1'b0, 10'd3, '0);
        exp = exp_q.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.data_out !== exp) begin
            errors++;
            $display("FAIL clear_blocked: rd_valid=%b data_out=%h, required 1/%h",
                     bus.rd_valid, bus.data_out, exp);
        end
        last_rd = exp;
    endtask

    task automatic test_back_to_back();
        logic              r, w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, exp;
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = ADDR_W'($urandom_range(8, 15));
            d = DATA_W'($urandom);
            drive(r, w, a, d);
            checks++;
            if (r) begin
                exp = exp_q.pop_front();
                if (bus.rd_valid !== 1'b1 || bus.data_out !== exp) begin
                    errors++;
                    $display("FAIL b2b_read: step %0d addr %0d rd_valid=%b data_out=%h, required 1/%h",
                             i, a, bus.rd_valid, bus.data_out, exp);
                end
                last_rd = exp;
            end else if (bus.rd_valid !== 1'b0 || bus.data_out !== last_rd) begin
                errors++;
                $display("FAIL b2b_hold: step %0d rd_valid=%b data_out=%h, required 0/%h",
                         i, bus.rd_valid, bus.data_out, last_rd);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [DATA_W-1:0] exp;
        drive(1'b0, 1'b1, 10'd1023, 16'hFFFF);
        drive(1'b1, 1'b0, 10'd1023, '0);
        exp = exp_q.pop_front();
        checks++;
        if (bus.data_out !== exp) begin
            errors++;
            $display("FAIL pre_reset_read: data_out=%h, required %h", bus.data_out, exp);
        end
        bus.rd = 1'b0;
        #2;
        rst_n     = 1'b0;
        mdl_ready = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 16'h0 || bus.ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: data_out=%h ready=%b rd_valid=%b, required 0/0/0",
                     bus.data_out, bus.ready, bus.rd_valid);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        n = 0;
        while (n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready === 1'b1) break;
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL reclear_length: ready after %0d cycles, required %0d", n, DEPTH);
        end
        model_clear();
        drive(1'b1, 1'b0, 10'd1023, '0);
        exp = exp_q.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.data_out !== exp) begin
            errors++;
            $display("FAIL reclear_read: rd_valid=%b data_out=%h, required 1/%h",
                     bus.rd_valid, bus.data_out, exp);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_collision();
        test_clear_blocked();
        test_back_to_back();
        test_mid_reset();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_1k16.md
Name: ram_1k16

Overview:
- Single-port synchronous word RAM: 1024 x 16 by default, with registered read data and a hardware clear engine.
- Serves as the working data store for the sorting datapath; the controller writes elements, then reads them back by address.
- After every reset the block zeroes all memory locations before accepting accesses.

Parameters:
- DATA_W, 16, width of a data word in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words (1024 by default).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  write data.
- rd  input  1  read enable.
- wr  input  1  write enable.
- address  input  ADDR_W  word address for the read or write.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  high for one cycle when data_out carries data from a read accepted on the previous edge.
- ready  output  1  high when the clear engine is done and accesses are accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): data_out=0, rd_valid=0, ready=0, clear pointer=0. Memory array contents are not reset directly.
- Clear engine:
  - Starts on the first rising edge after rst_n deasserts.
  - Writes 0 to address 0, 1, ..., DEPTH-1, one word per cycle.
  - ready rises on the edge that writes the last word, so it is high on the cycle after that write.
  - Clear duration is exactly DEPTH cycles.
  - While ready=0, rd and wr are ignored: no write, data_out holds 0, rd_valid stays 0.
- Write (ready=1, wr=1): mem[address] <= data_in on the rising edge. Data is readable starting on the next edge.
- Read (ready=1, rd=1, wr=0):
  - data_out <= mem[address] on the rising edge (1-cycle latency).
  - rd_valid <= 1 for that following cycle.
- Simultaneous rd=1 and wr=1 (write-first):
  - The write is performed.
  - data_out <= data_in and rd_valid <= 1.
- rd=0: data_out holds its last value; rd_valid <= 0.
- Address is always in range, since DEPTH = 2**ADDR_W; there is no wrap or error logic.
- Reset asserted mid-operation:
  - Aborts any access immediately.
  - Outputs return to their reset values.
  - The clear engine restarts from address 0 after release.
- No combinational path from inputs to outputs; all outputs are registered.
- The memory array must be inferable as block RAM, with a single read/write port multiplexed with the clear engine.

Test Plan:
- Reset then clear: assert rst_n=0 for 2 cycles, release -> ready=0 for exactly 1024 cycles, then ready=1. Read of address 5 returns 0 with rd_valid=1 one cycle later.
- Write/read-back:
  - Write 1 to addr 1 and 2 to addr 2 on consecutive cycles, then deassert wr.
  - Read addr 1 then addr 2 -> data_out=1, then 2, each one cycle after the request, with rd_valid=1.
- Hold behaviour: after reading addr 2 (=2), drop rd for 3 cycles -> data_out stays 2, rd_valid=0.
- Write-first collision: rd=1, wr=1, addr 7, data_in=16'hBEEF -> next cycle data_out=16'hBEEF. A later plain read of addr 7 returns 16'hBEEF.
- Access during clear: issue wr to addr 3 with data 16'h1234 while ready=0 -> after ready=1, a read of addr 3 returns 0.
- Mid-operation reset:
  - Write 16'hFFFF to addr 1023, pulse rst_n low for 1 cycle -> data_out=0 and ready=0 immediately.
  - After the re-clear, a read of addr 1023 returns 0.
